sim_err_monitor: RTL and testbench
==================================

Name: sim_err_monitor

Overview:
- Checker that drives the `err` line consumed by the testbench clock/reset generator.
- Sits beside the DUT in every test top and watches progress (`heartbeat`), completion (`halt`) and per-unit error flags (`err_src`).
- Converts hangs, runaway runs, illegal post-halt activity and unit errors into one sticky, registered `err` plus a diagnostic code.
- Replaces ad-hoc per-test hang detection with one parameterised block.

Parameters:
- TIMEOUT, 1000: consecutive RUN cycles without `heartbeat` that constitute a hang (legal ≥2).
- MAX_CYCLES, 100000: RUN cycles allowed before a runaway fault.
- ARM_CYCLES, 2: cycles after reset release during which `err_src` is masked.
- SRC_W, 4: number of error-source inputs.
- CNT_W, 32: width of the cycle and idle counters.

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous, active-low reset.
- heartbeat  in  1  DUT made forward progress this cycle (e.g. instruction retired).
- halt  in  1  DUT reached normal completion.
- err_src  in  SRC_W  Per-unit error flags, active-high, sampled each cycle.
- err  out  1  Sticky error, registered.
- err_code  out  3  0 none, 1 source error, 2 hang, 3 runaway, 4 activity after halt.
- err_src_q  out  SRC_W  `err_src` captured on the faulting edge (code 1 only, else 0).
- cycle_cnt  out  CNT_W  RUN cycles elapsed, saturating.
- state  out  2  0 ARM, 1 RUN, 2 DONE, 3 FAULT.

Behaviour:
- Reset (rst=0 at a posedge):
  - state=ARM, err=0, err_code=0, err_src_q=0, cycle_cnt=0, internal idle_cnt=0, arm_cnt=0.
  - Reset overrides everything, including FAULT; a mid-run reset clears all state on that edge.
- All outputs are registered. A fault condition seen in cycle N gives err=1 and state=FAULT after edge N.
- ARM:
  - arm_cnt increments each cycle; `err_src` and `heartbeat` are ignored.
  - When arm_cnt==ARM_CYCLES-1, next state is RUN.
  - ARM_CYCLES=0 means the state after reset is RUN directly.
- RUN:
  - cycle_cnt increments each cycle, saturating at all-ones.
  - idle_cnt clears on heartbeat=1 and otherwise increments.
  - Transitions, evaluated in priority order each cycle:
    1. `err_src`≠0 → FAULT, code 1, err_src_q=err_src.
    2. heartbeat=0 and idle_cnt==TIMEOUT-1 → FAULT, code 2.
    3. cycle_cnt==MAX_CYCLES-1 and halt=0 → FAULT, code 3.
    4. halt=1 → DONE.
  - A heartbeat on the TIMEOUT-th idle cycle rescues the run (idle_cnt clears, no fault).
  - halt together with the final allowed cycle → DONE, not runaway.
  - halt together with `err_src`≠0 → FAULT, code 1.
- DONE:
  - Counters freeze; err stays 0.
  - heartbeat=1 → FAULT, code 4.
  - `err_src`≠0 → FAULT, code 1 (code 1 has priority if both occur).
  - halt may stay high or drop without effect.
- FAULT:
  - Absorbing until reset. err=1; err_code, err_src_q and cycle_cnt hold.
  - Further inputs are ignored; the first cause is always the one reported.
- No combinational path from any input to any output.
- Counter comparisons are equality checks on CNT_W-bit values. Parameters must fit in CNT_W; with defaults, a CNT_W below 17 is an elaboration error (generate check).
- X on `err_src` in RUN or DONE is treated as nonzero (use the reduction-OR result; no masking).

Test Plan (TIMEOUT=4, MAX_CYCLES=20, ARM_CYCLES=2, SRC_W=4 unless noted):
- Normal run: release rst, heartbeat every cycle, halt at RUN cycle 10 → state=DONE, err=0, cycle_cnt=10, held 50 more cycles.
- Hang: heartbeat for 3 RUN cycles then 0 → err=1 on the edge ending the 4th idle cycle, err_code=2. Repeat with heartbeat on the 4th idle cycle → no fault.
- Source error and masking:
  - err_src=4'b0100 during ARM → ignored.
  - err_src=4'b0110 in RUN cycle 5 → err=1 next edge, err_code=1, err_src_q=4'b0110.
  - err_src=4'b0001 in the same cycle as halt → err_code=1.
- Runaway: heartbeat always, no halt → FAULT at cycle_cnt=19→ err_code=3. halt asserted in RUN cycle 19 (0-based cycle_cnt==19) → DONE, no fault.
- Post-halt activity: reach DONE, then pulse heartbeat → err=1, err_code=4. Then err_src=4'b1000 → code stays 4.
- Reset mid-FAULT: in FAULT, assert rst=0 for 1 cycle → all outputs zero, state=ARM. Reset asserted but no posedge yet → outputs unchanged (synchronous).

Source files
------------

// File: rtl/sim_err_monitor.sv
// sim_err_monitor: watches heartbeat/halt/err_src and raises a sticky err with a first-cause code.
module sim_err_monitor #(
  parameter int TIMEOUT    = 1000,
  parameter int MAX_CYCLES = 100000,
  parameter int ARM_CYCLES = 2,
  parameter int SRC_W      = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             heartbeat,
  input  logic             halt,
  input  logic [SRC_W-1:0] err_src,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [SRC_W-1:0] err_src_q,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {ARM = 2'd0, RUN = 2'd1, DONE = 2'd2, FAULT = 2'd3} state_t;
  localparam longint LIM = (CNT_W >= 63) ? 64'sh7fff_ffff_ffff_ffff : (longint'(1) << CNT_W);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES > 0 ? ARM_CYCLES - 1 : 0);
  localparam state_t ST_RST = (ARM_CYCLES == 0) ? RUN : ARM;
  if (TIMEOUT < 2 || MAX_CYCLES < 1 || ARM_CYCLES < 0 || longint'(TIMEOUT) > LIM - 1 ||
      longint'(MAX_CYCLES) > LIM - 1 || longint'(ARM_CYCLES) > LIM - 1) begin : g_bad_params
    $error("sim_err_monitor: parameters do not fit CNT_W or TIMEOUT < 2");
  end
  state_t st, st_n;
  logic [CNT_W-1:0] arm_cnt, arm_cnt_n, idle_cnt, idle_cnt_n, cyc_n;
  logic [2:0] code_n;
  logic [SRC_W-1:0] srcq_n;
  logic src_hit;
  always_comb begin
    st_n = st;
    arm_cnt_n = arm_cnt;
    idle_cnt_n = idle_cnt;
    cyc_n = cycle_cnt;
    code_n = err_code;
    srcq_n = err_src_q;
    src_hit = |err_src;
    case (st)
      ARM: begin
        arm_cnt_n = arm_cnt + 1'b1;
        st_n = (arm_cnt == ARM_LAST) ? RUN : ARM;
      end
      RUN: begin
        cyc_n = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
        idle_cnt_n = heartbeat ? '0 : idle_cnt + 1'b1;
        if (src_hit) begin
          st_n = FAULT;
          code_n = 3'd1;
          srcq_n = err_src;
        end else if (!heartbeat && idle_cnt == TO_LAST) begin
          st_n = FAULT;
          code_n = 3'd2;
        end else if (cycle_cnt == MAX_LAST && !halt) begin
          st_n = FAULT;
          code_n = 3'd3;
        end else if (halt) begin
          st_n = DONE;
        end
      end
      DONE: begin
        if (src_hit) begin
          st_n = FAULT;
          code_n = 3'd1;
          srcq_n = err_src;
        end else if (heartbeat) begin
          st_n = FAULT;
          code_n = 3'd4;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= ST_RST;
      arm_cnt <= '0;
      idle_cnt <= '0;
      cycle_cnt <= '0;
      err <= 1'b0;
      err_code <= 3'd0;
      err_src_q <= '0;
    end else begin
      st <= st_n;
      arm_cnt <= arm_cnt_n;
      idle_cnt <= idle_cnt_n;
      cycle_cnt <= cyc_n;
      err <= (st_n == FAULT);
      err_code <= code_n;
      err_src_q <= srcq_n;
    end
  end
  assign state = st;
endmodule

// File: tb/tb_sim_err_monitor.sv
// tb_sim_err_monitor: directed scenarios plus random traffic checked against a rule-level model.
module tb_sim_err_monitor;
  localparam int TO = 4, MAXC = 20, ARMC = 2;
  logic clk = 0, rst = 0, heartbeat = 0, halt = 0;
  logic [3:0] err_src = '0;
  logic err;
  logic [2:0] err_code;
  logic [3:0] err_src_q;
  logic [31:0] cycle_cnt;
  logic [1:0] state;
  int nchk = 0, nerr = 0;
  sim_err_monitor #(.TIMEOUT(TO), .MAX_CYCLES(MAXC), .ARM_CYCLES(ARMC), .SRC_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .halt(halt), .err_src(err_src),
    .err(err), .err_code(err_code), .err_src_q(err_src_q), .cycle_cnt(cycle_cnt), .state(state));
  always #5 clk = ~clk;
  // Model: counts completed ARM cycles, RUN cycles and consecutive idle cycles (current cycle included).
  bit mvalid = 0;
  int m_st, m_arm, m_idle;
  logic [31:0] m_runs;
  logic [2:0] m_code;
  logic [3:0] m_src;
  task automatic mfault(input logic [2:0] c, input logic [3:0] s);
    m_st = 3; m_code = c; m_src = s;
  endtask
  always @(posedge clk) begin
    if (!rst) begin
      mvalid = 1; m_st = (ARMC == 0) ? 1 : 0;
      m_arm = 0; m_idle = 0; m_runs = 0; m_code = 0; m_src = 0;
    end else if (mvalid) begin
      if (m_st == 0) begin
        m_arm++;
        if (m_arm == ARMC) m_st = 1;
      end else if (m_st == 1) begin
        if (m_runs != '1) m_runs++;
        m_idle = heartbeat ? 0 : m_idle + 1;
        if (err_src != 0) mfault(3'd1, err_src);
        else if (m_idle == TO) mfault(3'd2, 4'd0);
        else if (m_runs == MAXC && !halt) mfault(3'd3, 4'd0);
        else if (halt) m_st = 2;
      end else if (m_st == 2) begin
        if (err_src != 0) mfault(3'd1, err_src);
        else if (heartbeat) mfault(3'd4, 4'd0);
      end
    end
  end
  always @(negedge clk) if (mvalid) begin
    nchk++;
    if ({err, err_code, err_src_q, cycle_cnt, state} !== {m_st == 3, m_code, m_src, m_runs, 2'(m_st)}) begin
      nerr++;
      $display("FAIL model t=%0t actual st=%0d err=%0b code=%0d srcq=%b cnt=%0d required st=%0d err=%0b code=%0d srcq=%b cnt=%0d",
               $time, state, err, err_code, err_src_q, cycle_cnt, m_st, m_st == 3, m_code, m_src, m_runs);
    end
  end
  task automatic chk(input string n, input longint a, input longint e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask
  task automatic cyc(input logic hb, input logic h, input logic [3:0] s);
    heartbeat = hb; halt = h; err_src = s;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 0; heartbeat = 0; halt = 0; err_src = '0;
    @(negedge clk);
    rst = 1;
  endtask
  task automatic to_run();
    do_reset();
    cyc(0, 0, 4'b0100);
    cyc(0, 0, 4'b0100);
  endtask
  initial begin
    @(negedge clk);
    rst = 1;
    chk("reset_state", state, 0);
    chk("reset_err", err, 0);
    // normal run, with err_src masked during ARM
    to_run();
    chk("arm_masked_state", state, 1);
    chk("arm_masked_err", err, 0);
    repeat (9) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("normal_state", state, 2);
    chk("normal_cnt", cycle_cnt, 10);
    for (int i = 0; i < 50; i++) cyc(0, 1'($urandom_range(0, 1)), 0);
    chk("normal_hold_state", state, 2);
    chk("normal_hold_cnt", cycle_cnt, 10);
    chk("normal_hold_err", err, 0);
    // hang
    to_run();
    repeat (3) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("hang_pre_err", err, 0);
    cyc(0, 0, 0);
    chk("hang_err", err, 1);
    chk("hang_code", err_code, 2);
    // heartbeat on the 4th idle cycle rescues
    to_run();
    repeat (3) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("rescue_err", err, 0);
    chk("rescue_state", state, 1);
    // source error in RUN cycle 5
    to_run();
    repeat (5) cyc(1, 0, 0);
    cyc(1, 0, 4'b0110);
    chk("src_code", err_code, 1);
    chk("src_q", err_src_q, 4'b0110);
    chk("src_cnt", cycle_cnt, 6);
    cyc(0, 1, 4'b1001);
    chk("src_hold_q", err_src_q, 4'b0110);
    // source error together with halt
    to_run();
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 4'b0001);
    chk("src_halt_code", err_code, 1);
    // runaway
    to_run();
    repeat (19) cyc(1, 0, 0);
    chk("runaway_pre_err", err, 0);
    cyc(1, 0, 0);
    chk("runaway_code", err_code, 3);
    chk("runaway_cnt", cycle_cnt, 20);
    // halt on the final allowed cycle
    to_run();
    repeat (19) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("last_halt_state", state, 2);
    chk("last_halt_err", err, 0);
    // post-halt activity, then later source error keeps code 4
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("post_halt_code", err_code, 4);
    cyc(0, 0, 4'b1000);
    chk("post_halt_keep", err_code, 4);
    chk("post_halt_srcq", err_src_q, 0);
    // reset while in FAULT is synchronous
    rst = 0;
    #1;
    chk("rst_async_state", state, 3);
    chk("rst_async_err", err, 1);
    @(negedge clk);
    rst = 1;
    chk("rst_state", state, 0);
    chk("rst_code", err_code, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_err", err, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
          ($urandom_range(0, 49) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
    end
    rst = 1;
    cyc(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
